sram_host_if: RTL and testbench
===============================

Name: sram_host_if

Overview:
- Host-side initiator for the on-chip SRAM macro's 2-cycle control FSM.
- Accepts single read/write requests over a valid/ready request channel and sequences the SRAM control inputs: enable pulse, read_not_write, address and write data.
- Checks the control block's ready handshake, captures read data, and returns one response per request over a valid/ready response channel.
- Sits between the Tiny Tapeout pin/command decoder and the SRAM core.

Parameters:
ADDR_W, 5, SRAM address width (rows and columns combined).
DATA_W, 8, SRAM word width.
TIMEOUT_CYCLES, 15, maximum wait for mem_ready in CAPTURE; used only with SRAM_HOST_TIMEOUT_EN; legal range 1..255.

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid & req_ready
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_err  out  1  handshake violation or timeout on this operation
mem_enable  out  1  chip-select pulse to the SRAM control
mem_read_not_write  out  1  1=read, 0=write
mem_addr  out  ADDR_W  address to the row/column decoders
mem_wdata  out  DATA_W  data to the write drivers
mem_ready  in  1  ready from the SRAM control (high in IDLE and in CYCLE2)
mem_rdata  in  DATA_W  column-mux read data, valid in CYCLE2
busy  out  1  high in every state except H_IDLE

Behaviour:
- Reset values: state H_IDLE; req_ready=1; rsp_valid=0; rsp_rdata=0; rsp_err=0; mem_enable=0; mem_read_not_write=1; mem_addr=0; mem_wdata=0; busy=0.
- Reset asserted mid-operation aborts it immediately. No response is produced and all outputs return to reset values.
- req_ready=1 only in H_IDLE; one operation outstanding at most.
- All mem_* outputs are registered.
- H_IDLE:
  - On req_valid & req_ready, latch req_write, req_addr and req_wdata into mem_read_not_write (=!req_write), mem_addr and mem_wdata.
  - Clear the error flag and go to H_ISSUE.
- H_ISSUE (1 cycle):
  - mem_enable=1.
  - mem_ready must be 1 (control idle); if 0, set the error flag.
  - Go to H_WAIT.
- H_WAIT (1 cycle):
  - mem_enable=0; control is in CYCLE1.
  - mem_ready must be 0; if 1, set the error flag.
  - Go to H_CAPTURE.
- H_CAPTURE:
  - mem_enable=0, so control returns to IDLE rather than restarting.
  - mem_ready must be 1.
  - If mem_read_not_write=1, register mem_rdata into rsp_rdata; otherwise load rsp_rdata=0.
  - If mem_ready=0, set the error flag.
  - Go to H_RESP.
- H_RESP:
  - rsp_valid=1 and rsp_err=error flag.
  - rsp_rdata, rsp_err and rsp_valid are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to H_IDLE (rsp_valid=0 next cycle).
- mem_addr, mem_wdata and mem_read_not_write stay constant from H_ISSUE through H_CAPTURE. They hold their last values in H_RESP and H_IDLE.
- Latency: acceptance edge to rsp_valid high = 4 cycles. With rsp_ready tied high, sustained throughput is 1 operation per 5 cycles.
- Simultaneous events:
  - req_valid in H_RESP is not accepted; req_ready=0.
  - rsp_ready while rsp_valid=0 is ignored.
- Illegal state encodings recover to H_IDLE.

Optional Feature:
- Macro SRAM_HOST_TIMEOUT_EN.
- Defined:
  - H_CAPTURE waits while mem_ready=0, counting cycles with an 8-bit counter cleared on entry.
  - Data is captured on the first cycle with mem_ready=1.
  - If the count reaches TIMEOUT_CYCLES with mem_ready still 0, rsp_rdata=0, the error flag is set, and the FSM goes to H_RESP.
  - The H_WAIT check still applies.
- Undefined:
  - H_CAPTURE is exactly 1 cycle and mem_ready=0 there sets the error flag.
  - No counter is synthesised.

Test Plan:
- Write then read: write addr 5'h0A data 8'hA5, then read 5'h0A, with a bench model of the 2-cycle control. Required:
  - mem_enable high exactly 1 cycle per operation.
  - Both responses arrive 4 cycles after acceptance with rsp_err=0.
  - The read returns 8'hA5; the write response has rsp_rdata=0.
- Back-pressure: hold rsp_ready=0 for 6 cycles after a read response. Required: rsp_valid, rsp_rdata and rsp_err stay stable, req_ready stays 0, and the FSM returns to H_IDLE the cycle after rsp_ready=1.
- Handshake violation: the model holds mem_ready=1 through CYCLE1. Required: rsp_err=1 on that response; the next request completes with rsp_err=0.
- Reset mid-operation: assert rst_n=0 in H_WAIT. Required: all outputs take reset values asynchronously, no rsp_valid follows, and req_ready=1 after release.
- Address sweep: write DATA=addr^8'h3C to addresses 0..31, then read back. Required: all 32 reads match and mem_addr is stable from H_ISSUE through H_CAPTURE.
- With SRAM_HOST_TIMEOUT_EN:
  - Model delays mem_ready by 3 cycles in CAPTURE: correct data is captured with rsp_err=0.
  - Model never asserts mem_ready: rsp_err=1 and rsp_rdata=0 after TIMEOUT_CYCLES=15 wait cycles.

Source files
------------

// File: rtl/sram_host_if.sv
// rtl/sram_host_if.sv - host initiator sequencing the SRAM 2-cycle control FSM
// Optional SRAM_HOST_TIMEOUT_EN: CAPTURE waits for mem_ready up to TIMEOUT_CYCLES.
module sram_host_if #(
  parameter int ADDR_W         = 5,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              mem_enable,
  output logic              mem_read_not_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("sram_host_if: TIMEOUT_CYCLES out of range 1..255");
  end

  typedef enum logic [2:0] {
    H_IDLE    = 3'd0,
    H_ISSUE   = 3'd1,
    H_WAIT    = 3'd2,
    H_CAPTURE = 3'd3,
    H_RESP    = 3'd4
  } state_t;

  state_t            state, state_nx;
  logic              err, err_nx;
  logic              mem_enable_nx, rnw_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic [DATA_W-1:0] wdata_nx, rdata_nx;
  logic              rsp_valid_nx, rsp_err_nx;

`ifdef SRAM_HOST_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt, wait_cnt_nx;
`endif

  assign req_ready = (state == H_IDLE);
  assign busy      = (state != H_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= H_IDLE;
      err                <= 1'b0;
      mem_enable         <= 1'b0;
      mem_read_not_write <= 1'b1;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      rsp_valid          <= 1'b0;
      rsp_err            <= 1'b0;
      rsp_rdata          <= '0;
`ifdef SRAM_HOST_TIMEOUT_EN
      wait_cnt           <= 8'd0;
`endif
    end else begin
      state              <= state_nx;
      err                <= err_nx;
      mem_enable         <= mem_enable_nx;
      mem_read_not_write <= rnw_nx;
      mem_addr           <= addr_nx;
      mem_wdata          <= wdata_nx;
      rsp_valid          <= rsp_valid_nx;
      rsp_err            <= rsp_err_nx;
      rsp_rdata          <= rdata_nx;
`ifdef SRAM_HOST_TIMEOUT_EN
      wait_cnt           <= wait_cnt_nx;
`endif
    end
  end

  always_comb begin
    state_nx      = state;
    err_nx        = err;
    mem_enable_nx = 1'b0;
    rnw_nx        = mem_read_not_write;
    addr_nx       = mem_addr;
    wdata_nx      = mem_wdata;
    rdata_nx      = rsp_rdata;
    rsp_valid_nx  = rsp_valid;
    rsp_err_nx    = rsp_err;
`ifdef SRAM_HOST_TIMEOUT_EN
    wait_cnt_nx   = wait_cnt;
`endif
    case (state)
      H_IDLE: begin
        if (req_valid) begin
          rnw_nx        = ~req_write;
          addr_nx       = req_addr;
          wdata_nx      = req_wdata;
          err_nx        = 1'b0;
          mem_enable_nx = 1'b1;
          state_nx      = H_ISSUE;
        end
      end
      H_ISSUE: begin
        if (!mem_ready) err_nx = 1'b1;
        state_nx = H_WAIT;
      end
      H_WAIT: begin
        // Control sits in CYCLE1 here, so ready must be low.
        if (mem_ready) err_nx = 1'b1;
`ifdef SRAM_HOST_TIMEOUT_EN
        wait_cnt_nx = 8'd0;
`endif
        state_nx = H_CAPTURE;
      end
      H_CAPTURE: begin
`ifdef SRAM_HOST_TIMEOUT_EN
        if (mem_ready) begin
          rdata_nx     = mem_read_not_write ? mem_rdata : '0;
          state_nx     = H_RESP;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = err;
        end else if (wait_cnt == WAIT_LAST) begin
          rdata_nx     = '0;
          err_nx       = 1'b1;
          state_nx     = H_RESP;
          rsp_valid_nx = 1'b1;
          rsp_err_nx   = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + 8'd1;
        end
`else
        rdata_nx = mem_read_not_write ? mem_rdata : '0;
        if (!mem_ready) err_nx = 1'b1;
        state_nx     = H_RESP;
        rsp_valid_nx = 1'b1;
        rsp_err_nx   = err | ~mem_ready;
`endif
      end
      H_RESP: begin
        if (rsp_ready) begin
          state_nx     = H_IDLE;
          rsp_valid_nx = 1'b0;
          rsp_err_nx   = 1'b0;
        end
      end
      default: begin
        state_nx     = H_IDLE;
        rsp_valid_nx = 1'b0;
        rsp_err_nx   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_host_if.sv
// tb/tb_sram_host_if.sv - directed and random checks of sram_host_if against a behavioural SRAM model
module tb_sram_host_if;

  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [4:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       rsp_valid;
  logic       rsp_ready = 1'b0;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       mem_enable;
  logic       mem_read_not_write;
  logic [4:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_ready;
  logic [7:0] mem_rdata;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  sram_host_if dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_enable(mem_enable), .mem_read_not_write(mem_read_not_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  // SRAM control: IDLE -> CYCLE1 -> CYCLE2 (optionally stretched) -> IDLE
  int         c_state;
  int         c_delay;
  int         delay_cfg = 0;
  logic       hold_cfg = 1'b0;
  logic [7:0] sram [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_state <= 0;
      c_delay <= 0;
    end else begin
      case (c_state)
        0: if (mem_enable) c_state <= 1;
        1: begin c_state <= 2; c_delay <= delay_cfg; end
        default: begin
          if (c_delay > 0) c_delay <= c_delay - 1;
          else begin
            if (!mem_read_not_write) sram[mem_addr] <= mem_wdata;
            c_state <= mem_enable ? 1 : 0;
          end
        end
      endcase
    end
  end

  assign mem_ready = (c_state == 0) || (c_state == 1 && hold_cfg) || (c_state == 2 && c_delay == 0);
  assign mem_rdata = sram[mem_addr];

  logic [7:0] ref_mem [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk("rst_mem_enable", 32'(mem_enable), 32'd0);
    chk("rst_mem_rnw",   32'(mem_read_not_write), 32'd1);
    chk("rst_mem_addr",  32'(mem_addr),  32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
  endtask

  // Runs one operation starting at a negedge; checks control sequencing on the way.
  task automatic do_op(input logic wr, input logic [4:0] a, input logic [7:0] d, input int hold,
                       output logic [7:0] rd, output logic er, output int lat);
    int  en;
    bit  done;
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    lat = 1;
    #1 req_valid = 1'b0;
    en = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (rsp_valid) done = 1;
      else begin
        if (mem_enable) en++;
        chk("mem_addr_stable",  32'(mem_addr), 32'(a));
        chk("mem_rnw_stable",   32'(mem_read_not_write), 32'(!wr));
        chk("mem_wdata_stable", 32'(mem_wdata), 32'(d));
        @(posedge clk);
        lat++;
      end
    end
    if (!done) chk("rsp_timeout", 32'd0, 32'd1);
    chk("enable_pulses", 32'(en), 32'd1);
    rd = rsp_rdata;
    er = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", 32'(rsp_rdata), 32'(rd));
      chk("bp_err",   32'(rsp_err),   32'(er));
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_released", 32'(rsp_valid), 32'd0);
    chk("back_to_idle", 32'(req_ready), 32'd1);
  endtask

  task automatic op_checked(input logic wr, input logic [4:0] a, input logic [7:0] d, input int hold,
                            input logic exp_err, input int exp_lat, input logic timed_out);
    logic [7:0] rd, exp_rd;
    logic       er;
    int         lat;
    exp_rd = (wr || timed_out) ? 8'h00 : ref_mem[a];
    do_op(wr, a, d, hold, rd, er, lat);
    chk("rsp_rdata", 32'(rd), 32'(exp_rd));
    chk("rsp_err",   32'(er), 32'(exp_err));
    chk("latency",   32'(lat), 32'(exp_lat));
    if (wr) ref_mem[a] = d;
  endtask

  initial begin
    logic [4:0] ra;
    logic [7:0] rdv;
    logic       rw;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h00;

    repeat (2) @(negedge clk);
    chk_reset_vals();
    rst_n = 1'b1;
    @(negedge clk);

    // write then read
    op_checked(1'b1, 5'h0A, 8'hA5, 0, 1'b0, LAT, 1'b0);
    op_checked(1'b0, 5'h0A, 8'h00, 6, 1'b0, LAT, 1'b0);

    // control holds ready through CYCLE1
    hold_cfg = 1'b1;
    op_checked(1'b0, 5'h0A, 8'h00, 0, 1'b1, LAT, 1'b0);
    hold_cfg = 1'b0;
    op_checked(1'b0, 5'h0A, 8'h00, 0, 1'b0, LAT, 1'b0);

    // reset in H_WAIT
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'h0A;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1 chk_reset_vals();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
      chk("post_rst_ready",  32'(req_ready), 32'd1);
    end

    // address sweep
    for (int a = 0; a < 32; a++)
      op_checked(1'b1, 5'(a), 8'(a) ^ 8'h3C, 0, 1'b0, LAT, 1'b0);
    for (int a = 0; a < 32; a++)
      op_checked(1'b0, 5'(a), 8'h00, 0, 1'b0, LAT, 1'b0);

    // mem_ready late in CAPTURE
    delay_cfg = 3;
`ifdef SRAM_HOST_TIMEOUT_EN
    op_checked(1'b0, 5'h07, 8'h00, 0, 1'b0, LAT + 3, 1'b0);
`else
    op_checked(1'b0, 5'h07, 8'h00, 0, 1'b1, LAT, 1'b0);
    repeat (6) @(negedge clk);
`endif
    delay_cfg = 0;

    // random traffic
    for (int i = 0; i < 40; i++) begin
      rw  = 1'($urandom_range(0, 1));
      ra  = 5'($urandom_range(0, 31));
      rdv = 8'($urandom_range(0, 255));
      op_checked(rw, ra, rdv, $urandom_range(0, 2), 1'b0, LAT, 1'b0);
    end

`ifdef SRAM_HOST_TIMEOUT_EN
    // control never returns ready: 15 wait cycles in CAPTURE then error
    delay_cfg = 1000;
    op_checked(1'b0, 5'h05, 8'h00, 0, 1'b1, LAT + 14, 1'b1);
    delay_cfg = 0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    op_checked(1'b0, 5'h05, 8'h00, 0, 1'b0, LAT, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
